store_queue: RTL
================

# store_queue

Write-buffer stage between the ALU/accumulator demux and the data RAM. Accepts 32-bit store results with a 16-bit address through a valid/ready handshake, queues up to DEPTH entries in FIFO order, and drains them to the RAM one at a time, waiting on the RAM's done strobe for each write. This decouples ALU result production from RAM write latency, and adds a flush handshake for ordering points.

## Interface
- DATA_W, 32: store data width
- ADDR_W, 16: RAM address width
- DEPTH, 4: queue entries; power of two, at least 2
- clk  in  1  sole clock; rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a store
- in_ready  out  1  queue can accept; equals !full && !flushing
- in_data  in  DATA_W  store data
- in_addr  in  ADDR_W  store address
- ram_wre  out  1  one-cycle write strobe to RAM
- ram_data  out  DATA_W  head entry data
- ram_addr  out  ADDR_W  head entry address
- ram_done  in  1  RAM write-complete strobe
- flush  in  1  single-cycle flush request
- flush_done  out  1  one-cycle pulse when the flush completes
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  occupancy flags
- wr_count  out  16  completed RAM writes; wraps modulo 2^16
- lk_addr  in  ADDR_W  forwarding lookup address
- lk_hit, lk_data  out  1 / DATA_W  forwarding result

## Operation
- Push occurs on a rising edge with in_valid && in_ready. Data goes to the tail slot; the tail pointer wraps at DEPTH.
- in_ready, full and empty derive from the registered count only. There is no same-cycle pass-through. When full, a push is refused even if a pop happens on the same edge.
- Drain FSM has three states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when count != 0.
  - ISSUE lasts exactly one cycle with ram_wre=1, then moves to WAIT.
  - In WAIT, ram_done pops the head, increments wr_count and goes to ISSUE if the post-pop count is nonzero, otherwise to IDLE.
- ram_done is ignored outside WAIT.
- ram_addr and ram_data show the head entry and stay stable from ISSUE until the popping edge.
- A push and a pop on the same edge leave count unchanged.
- Flush:
  - When flush is sampled high, the internal flushing flag sets and in_ready drops the next cycle.
  - When count==0 and the FSM is in IDLE, flush_done pulses for one cycle and flushing clears.
  - A flush on an already-empty, idle queue pulses flush_done on the next cycle.
  - flush while flushing is ignored.
- Forwarding: see Configuration.

## Timing
- Reset values: in_ready=1, ram_wre=0, ram_data=0, ram_addr=0, flush_done=0, count=0, full=0, empty=1, wr_count=0, lk_hit=0, lk_data=0. FSM=IDLE, pointers=0, flushing=0.
- Latency on an empty, idle queue: a push at edge E0 gives count=1 after E0, FSM reaches ISSUE at E1, and ram_wre is high in the cycle after E1.
- Earliest ram_done is accepted in the cycle after ram_wre. Steady-state throughput is one write per 2 cycles with zero-wait RAM.
- rst mid-operation, including in WAIT: all state is discarded on that edge and pending entries are lost. ram_wre is 0 from the next cycle. A ram_done that arrives after reset is ignored because the FSM is in IDLE.
- wr_count wraps from 0xFFFF to 0x0000 with no flag.

## Configuration
- Macro STORE_QUEUE_FWD_EN.
- Defined:
  - lk_hit/lk_data are combinational from lk_addr.
  - All valid entries are searched, including the head while it is in ISSUE or WAIT.
  - The youngest matching entry wins.
  - No match gives lk_hit=0 and lk_data=0.
- Not defined: the ports remain, lk_hit and lk_data are tied to 0, and no compare logic is built.

## Test plan
- Reset: after rst → in_ready=1, empty=1, count=0, ram_wre=0, wr_count=0.
- Single store: push 0xDEADBEEF @0x0010, ram_done returned 3 cycles after ram_wre.
  - ram_wre is high for exactly one cycle, 2 edges after the push, with ram_addr=0x0010 and ram_data=0xDEADBEEF held until done.
  - Afterwards count=0 and wr_count=1.
- Full: ram_done held low, push 0x1..0x4 @0x0..0x3.
  - full=1, in_ready=0, and a 5th push of 0x5 is not accepted.
  - After pulsing done 4 times, writes appear in order 0x1,0x2,0x3,0x4 and empty=1.
- Flush: 2 entries pending, pulse flush.
  - in_ready=0 from the next cycle.
  - flush_done pulses once, one cycle after the second pop.
  - in_ready returns to 1 after the pulse.
- Forwarding: push 0xA @0x0020 then 0xB @0x0020 and set lk_addr=0x0020.
  - With STORE_QUEUE_FWD_EN: lk_hit=1, lk_data=0xB.
  - Without it: lk_hit=0, lk_data=0.
- Reset in WAIT: assert rst while ram_wre has fired and done is pending, then return ram_done a cycle later.
  - count=0 and ram_wre=0.
  - wr_count stays 0 and the late done is ignored.

Source files
------------

// File: rtl/store_queue.sv
// Store write-buffer between the ALU result demux and the data RAM: FIFO of DEPTH entries drained one
// write at a time with a done handshake, plus a flush handshake. Optional forwarding via STORE_QUEUE_FWD_EN.
module store_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       ram_wre,
    output logic [DATA_W-1:0]          ram_data,
    output logic [ADDR_W-1:0]          ram_addr,
    input  logic                       ram_done,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [15:0]                wr_count,
    input  logic [ADDR_W-1:0]          lk_addr,
    output logic                       lk_hit,
    output logic [DATA_W-1:0]          lk_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // state  | meaning
    // IDLE   | nothing in flight; leaves as soon as an entry is queued
    // ISSUE  | one-cycle ram_wre strobe for the head entry
    // WAIT   | head written, waiting for ram_done to pop it
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                ram_wre_q, ram_wre_d;
    logic                flushing_q, flushing_d;
    logic                flush_done_q, flush_done_d;
    logic                push, pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full && !flushing_q;
    assign count      = count_q;
    assign wr_count   = wr_count_q;
    assign ram_wre    = ram_wre_q;
    assign flush_done = flush_done_q;
    assign ram_data   = data_q[head_q];
    assign ram_addr   = addr_q[head_q];

    always_comb begin
        push         = in_valid && in_ready;
        pop          = (state_q == S_WAIT) && ram_done;
        count_d      = count_q + CW'(push) - CW'(pop);
        head_d       = pop  ? head_q + PW'(1) : head_q;
        tail_d       = push ? tail_q + PW'(1) : tail_q;
        wr_count_d   = wr_count_q + 16'(pop);
        state_d      = state_q;
        ram_wre_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d   = S_ISSUE;
                    ram_wre_d = 1'b1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ram_done) begin
                    if (count_d != '0) begin
                        state_d   = S_ISSUE;
                        ram_wre_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flush arriving while one is pending merges into it.
        flush_done_d = flushing_q && (count_q == '0) && (state_q == S_IDLE);
        flushing_d   = flush_done_d ? 1'b0 : (flushing_q || flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            wr_count_q   <= '0;
            ram_wre_q    <= 1'b0;
            flushing_q   <= 1'b0;
            flush_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            wr_count_q   <= wr_count_d;
            ram_wre_q    <= ram_wre_d;
            flushing_q   <= flushing_d;
            flush_done_q <= flush_done_d;
            if (push) begin
                data_q[tail_q] <= in_data;
                addr_q[tail_q] <= in_addr;
            end
        end
    end

`ifdef STORE_QUEUE_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic lk_unused;
    assign lk_unused = ^lk_addr;
    assign lk_hit    = 1'b0;
    assign lk_data   = '0;
`endif

endmodule
